// File: rtl/alu_op_sequencer.sv
// Command-side issuer for the 16-bit functionSelector ALU: accepts ops, drives registered
// operands, captures the 17-bit result into an accumulator and returns it with sticky error.
module alu_op_sequencer (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        cmd_valid_i,
    output logic        cmd_ready_o,
    input  logic [3:0]  cmd_op_i,
    input  logic [15:0] cmd_x_i,
    input  logic [15:0] cmd_y_i,
    input  logic        cmd_use_acc_i,
    output logic [15:0] alu_x_o,
    output logic [15:0] alu_y_o,
    output logic [2:0]  alu_op_o,
    input  logic [16:0] alu_out_i,
    input  logic        alu_err_i,
    output logic        res_valid_o,
    input  logic        res_ready_i,
    output logic [16:0] res_data_o,
    output logic        res_err_o,
    output logic        err_flag_o
);

    localparam int unsigned OPND_W = 16;
    localparam int unsigned RES_W  = 17;
    localparam int unsigned ALUOP_W = 3;
    localparam logic [3:0]  OP_CLEAR = 4'd8;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_EXEC = 2'd1,
        S_RESP = 2'd2
    } state_e;

    state_e               state_q, state_d;
    logic [OPND_W-1:0]    x_q, x_d;
    logic [OPND_W-1:0]    y_q, y_d;
    logic [ALUOP_W-1:0]   op_q, op_d;
    logic [RES_W-1:0]     acc_q, acc_d;
    logic                 err_q, err_d;
    logic                 res_err_q, res_err_d;
    logic                 res_valid_q, res_valid_d;
    logic                 ready_q, ready_d;

    logic accept_c;
    logic is_alu_c;
    logic is_clear_c;
    logic blocked_c;

    assign accept_c   = cmd_valid_i && ready_q;
    assign is_alu_c   = (cmd_op_i[3] == 1'b0);
    assign is_clear_c = (cmd_op_i == OP_CLEAR);
    // An accumulator-sourced op cannot trust acc while an overflow is outstanding
    assign blocked_c  = is_alu_c && err_q && cmd_use_acc_i;

    // Next-state and registered-output logic
    always_comb begin
        state_d     = state_q;
        x_d         = x_q;
        y_d         = y_q;
        op_d        = op_q;
        acc_d       = acc_q;
        err_d       = err_q;
        res_err_d   = res_err_q;
        res_valid_d = res_valid_q;
        ready_d     = ready_q;

        case (state_q)
            S_IDLE: begin
                ready_d = 1'b1;
                if (accept_c) begin
                    ready_d = 1'b0;
                    if (is_alu_c && !blocked_c) begin
                        x_d     = cmd_use_acc_i ? acc_q[OPND_W-1:0] : cmd_x_i;
                        y_d     = cmd_y_i;
                        op_d    = cmd_op_i[ALUOP_W-1:0];
                        state_d = S_EXEC;
                    end else if (is_clear_c) begin
                        acc_d       = '0;
                        err_d       = 1'b0;
                        res_err_d   = 1'b0;
                        res_valid_d = 1'b1;
                        state_d     = S_RESP;
                    end else begin
                        res_err_d   = 1'b1;
                        res_valid_d = 1'b1;
                        state_d     = S_RESP;
                    end
                end
            end
            S_EXEC: begin
                acc_d       = alu_out_i;
                res_err_d   = (op_q == ALUOP_W'(0)) && alu_err_i;
                if (res_err_d) begin
                    err_d = 1'b1;
                end
                res_valid_d = 1'b1;
                state_d     = S_RESP;
            end
            S_RESP: begin
                if (res_ready_i) begin
                    res_valid_d = 1'b0;
                    ready_d     = 1'b1;
                    state_d     = S_IDLE;
                end
            end
            default: begin
                state_d     = S_IDLE;
                res_valid_d = 1'b0;
                ready_d     = 1'b0;
            end
        endcase
    end

    // State and output registers, synchronous active-low reset
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q     <= S_IDLE;
            x_q         <= '0;
            y_q         <= '0;
            op_q        <= '0;
            acc_q       <= '0;
            err_q       <= 1'b0;
            res_err_q   <= 1'b0;
            res_valid_q <= 1'b0;
            ready_q     <= 1'b0;
        end else begin
            state_q     <= state_d;
            x_q         <= x_d;
            y_q         <= y_d;
            op_q        <= op_d;
            acc_q       <= acc_d;
            err_q       <= err_d;
            res_err_q   <= res_err_d;
            res_valid_q <= res_valid_d;
            ready_q     <= ready_d;
        end
    end

    assign cmd_ready_o = ready_q;
    assign alu_x_o     = x_q;
    assign alu_y_o     = y_q;
    assign alu_op_o    = op_q;
    assign res_valid_o = res_valid_q;
    assign res_data_o  = acc_q;
    assign res_err_o   = res_err_q;
    assign err_flag_o  = err_q;

endmodule

// File: tb/tb_alu_op_sequencer.sv
// Scoreboard bench for alu_op_sequencer with a behavioural stand-in for the functionSelector ALU.
module tb_alu_op_sequencer;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        cmd_valid;
    logic        cmd_ready;
    logic [3:0]  cmd_op;
    logic [15:0] cmd_x;
    logic [15:0] cmd_y;
    logic        cmd_use_acc;
    logic [15:0] alu_x;
    logic [15:0] alu_y;
    logic [2:0]  alu_op;
    logic [16:0] alu_out;
    logic        alu_err;
    logic        res_valid;
    logic        res_ready;
    logic [16:0] res_data;
    logic        res_err;
    logic        err_flag;

    always #5 clk = ~clk;

    alu_op_sequencer dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .cmd_valid_i   (cmd_valid),
        .cmd_ready_o   (cmd_ready),
        .cmd_op_i      (cmd_op),
        .cmd_x_i       (cmd_x),
        .cmd_y_i       (cmd_y),
        .cmd_use_acc_i (cmd_use_acc),
        .alu_x_o       (alu_x),
        .alu_y_o       (alu_y),
        .alu_op_o      (alu_op),
        .alu_out_i     (alu_out),
        .alu_err_i     (alu_err),
        .res_valid_o   (res_valid),
        .res_ready_i   (res_ready),
        .res_data_o    (res_data),
        .res_err_o     (res_err),
        .err_flag_o    (err_flag)
    );

    // ALU behaviour: {err, result}; the flag is only meaningful for add and is noisy elsewhere
    function automatic logic [17:0] alu_fn(input logic [2:0] op, input logic [15:0] x, input logic [15:0] y);
        logic [16:0] r;
        logic        e;
        case (op)
            3'd0:    begin r = {1'b0, x} + {1'b0, y}; e = r[16];  end
            3'd1:    begin r = {1'b0, x} - {1'b0, y}; e = (x < y); end
            3'd2:    begin r = {x, 1'b0};             e = x[15];   end
            3'd3:    begin r = {2'b00, x[15:1]};      e = x[0];    end
            3'd4:    begin r = {1'b0, x & y};         e = ^x;      end
            3'd5:    begin r = {1'b0, x | y};         e = ^y;      end
            3'd6:    begin r = {1'b0, x ^ y};         e = 1'b1;    end
            default: begin r = {1'b0, ~x};            e = 1'b1;    end
        endcase
        return {e, r};
    endfunction

    assign {alu_err, alu_out} = alu_fn(alu_op, alu_x, alu_y);

    typedef struct {
        logic [16:0] data;
        logic        err;
        logic        flag;
        logic [15:0] ax;
        logic [15:0] ay;
        logic [2:0]  aop;
        int          lat;
        int          acc_edge;
    } exp_t;

    exp_t        sb_q[$];
    int          n_chk  = 0;
    int          n_pass = 0;
    int          cyc    = 0;
    int          hold_req = 0;
    logic        in_resp = 1'b0;

    logic [16:0] m_acc;
    logic        m_flag;
    logic [15:0] m_ax;
    logic [15:0] m_ay;
    logic [2:0]  m_aop;

    always @(posedge clk) cyc <= cyc + 1;

    function automatic void chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    endfunction

    task automatic model_reset();
        m_acc = '0; m_flag = 1'b0; m_ax = '0; m_ay = '0; m_aop = '0;
    endtask

    // Issue one command and push the response the reference model predicts
    task automatic send(input logic [3:0] op, input logic [15:0] x, input logic [15:0] y, input logic ua);
        exp_t        e;
        logic [17:0] r;
        logic [2:0]  op3;
        int          t = 0;
        @(negedge clk);
        while (!cmd_ready && t < 100) begin @(negedge clk); t++; end
        if (!cmd_ready) begin
            n_chk++;
            $display("FAIL cmd_ready_timeout: got 0 expected 1 (cycle %0d)", cyc);
            return;
        end
        cmd_valid = 1'b1; cmd_op = op; cmd_x = x; cmd_y = y; cmd_use_acc = ua;
        op3 = op[2:0];
        if (op == 4'd8) begin
            m_acc = '0; m_flag = 1'b0; e.err = 1'b0; e.lat = 1;
        end else if (op > 4'd8 || (m_flag && ua)) begin
            e.err = 1'b1; e.lat = 1;
        end else begin
            m_ax  = ua ? m_acc[15:0] : x;
            m_ay  = y;
            m_aop = op3;
            r     = alu_fn(m_aop, m_ax, m_ay);
            m_acc = r[16:0];
            e.err = (op3 == 3'd0) && r[17];
            if (e.err) m_flag = 1'b1;
            e.lat = 2;
        end
        e.data = m_acc; e.flag = m_flag; e.ax = m_ax; e.ay = m_ay; e.aop = m_aop;
        e.acc_edge = cyc + 1;
        sb_q.push_back(e);
        @(posedge clk);
        #1;
        cmd_valid = 1'b0; cmd_op = 4'($urandom); cmd_x = 16'($urandom); cmd_y = 16'($urandom);
    endtask

    task automatic wait_idle();
        int t = 0;
        @(negedge clk);
        while ((sb_q.size() != 0 || in_resp || !cmd_ready) && t < 200) begin @(negedge clk); t++; end
        if (t >= 200) begin
            n_chk++;
            $display("FAIL idle_timeout: got queue %0d expected 0 (cycle %0d)", sb_q.size(), cyc);
        end
    endtask

    // Monitor: pops on each new response, checks hold stability and drives res_ready
    exp_t        cur;
    logic [16:0] s_data;
    logic        s_err;
    int          hold = 0;
    always @(negedge clk) begin
        if (!rst_n) begin
            in_resp   = 1'b0;
            res_ready = 1'b0;
        end else begin
            if (in_resp && res_ready) begin
                in_resp = 1'b0;
                chk("valid_drop", 32'(res_valid), 32'd0);
            end
            if (res_valid && !in_resp) begin
                if (sb_q.size() == 0) begin
                    n_chk++;
                    $display("FAIL unexpected_result: got data 0x%0h expected none", res_data);
                end else begin
                    cur = sb_q.pop_front();
                    chk("res_data", 32'(res_data), 32'(cur.data));
                    chk("res_err",  32'(res_err),  32'(cur.err));
                    chk("err_flag", 32'(err_flag), 32'(cur.flag));
                    chk("alu_x",    32'(alu_x),    32'(cur.ax));
                    chk("alu_y",    32'(alu_y),    32'(cur.ay));
                    chk("alu_op",   32'(alu_op),   32'(cur.aop));
                    chk("latency",  32'(cyc - cur.acc_edge + 1), 32'(cur.lat));
                end
                in_resp = 1'b1;
                s_data  = res_data;
                s_err   = res_err;
                hold    = (hold_req > 0) ? hold_req : int'($urandom_range(0, 2));
                hold_req = 0;
            end else if (in_resp) begin
                chk("hold_valid", 32'(res_valid), 32'd1);
                chk("hold_data",  32'(res_data),  32'(s_data));
                chk("hold_err",   32'(res_err),   32'(s_err));
                chk("hold_ready", 32'(cmd_ready), 32'd0);
                if (hold > 0) hold--;
            end
            res_ready = in_resp ? (hold == 0) : 1'($urandom_range(0, 1));
        end
    end

    initial begin
        int op_i;
        rst_n = 1'b0; cmd_valid = 1'b0; cmd_op = '0; cmd_x = '0; cmd_y = '0; cmd_use_acc = 1'b0;
        res_ready = 1'b0;
        model_reset();
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_cmd_ready", 32'(cmd_ready), 32'd0);
        chk("rst_res_valid", 32'(res_valid), 32'd0);
        chk("rst_res_data",  32'(res_data),  32'd0);
        chk("rst_res_err",   32'(res_err),   32'd0);
        chk("rst_err_flag",  32'(err_flag),  32'd0);
        chk("rst_alu_x",     32'(alu_x),     32'd0);
        chk("rst_alu_y",     32'(alu_y),     32'd0);
        chk("rst_alu_op",    32'(alu_op),    32'd0);
        rst_n = 1'b1;

        // Overflow, sticky block, CLEAR
        send(4'd0, 16'h0001, 16'hFFFF, 1'b0);
        send(4'd1, 16'h1234, 16'h0005, 1'b1);
        send(4'd2, 16'h0101, 16'h0000, 1'b0);
        send(4'd8, 16'h0000, 16'h0000, 1'b0);
        // Accumulate chain
        send(4'd0, 16'h00E1, 16'h0B01, 1'b0);
        send(4'd1, 16'h0000, 16'h00E1, 1'b1);
        send(4'd3, 16'h0000, 16'h0000, 1'b1);
        // Logic ops
        for (int i = 4; i < 8; i++) send(4'(i), 16'h00E1, 16'h0B01, 1'b0);
        // Backpressure, then illegal op
        hold_req = 5;
        send(4'd5, 16'hA5A5, 16'h0F0F, 1'b0);
        send(4'd12, 16'h1111, 16'h2222, 1'b0);
        wait_idle();

        // Randomized mix
        for (int n = 0; n < 80; n++) begin
            op_i = int'($urandom_range(0, 99));
            if (op_i < 70)      op_i = op_i % 8;
            else if (op_i < 80) op_i = 8;
            else                op_i = int'($urandom_range(9, 15));
            send(4'(op_i), 16'($urandom), 16'($urandom), 1'($urandom_range(0, 1)));
        end
        wait_idle();

        // Reset while EXEC: result discarded, all reset values applied
        send(4'd5, 16'h1234, 16'h0F00, 1'b0);
        wait_idle();
        while (!cmd_ready) @(negedge clk);
        cmd_valid = 1'b1; cmd_op = 4'd0; cmd_x = 16'hFFFF; cmd_y = 16'h0002; cmd_use_acc = 1'b0;
        @(posedge clk);
        #1;
        cmd_valid = 1'b0;
        @(negedge clk);
        chk("exec_valid", 32'(res_valid), 32'd0);
        chk("exec_ready", 32'(cmd_ready), 32'd0);
        rst_n = 1'b0;
        @(negedge clk);
        chk("midrst_valid", 32'(res_valid), 32'd0);
        chk("midrst_data",  32'(res_data),  32'd0);
        chk("midrst_flag",  32'(err_flag),  32'd0);
        chk("midrst_ready", 32'(cmd_ready), 32'd0);
        chk("midrst_alu_x", 32'(alu_x),     32'd0);
        rst_n = 1'b1;
        model_reset();
        send(4'd0, 16'h0010, 16'h0020, 1'b1);
        send(4'd7, 16'h00E1, 16'h0000, 1'b0);
        wait_idle();

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
